uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 115 +++++++++++
 tb/tb_uart_receiver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1-style serial receiver with 2-flop input synchronizer,
// mid-bit sampling, one-entry output register and sticky error flags.
module uart_receiver #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 rd_ack,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t               state, state_nx;
   logic                 rx_m, rx_s;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 bit_smp, stop_good, stop_bad;

   // Two-flop synchronizer; resets to the idle-high line level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // FSM next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (!rx_s) state_nx = S_START;
         S_START: if (cnt == HALF_M1) state_nx = rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (cnt == FULL_M1 && bit_idx == LAST_BIT) state_nx = S_STOP;
         S_STOP:  if (cnt == FULL_M1) state_nx = rx_s ? S_IDLE : S_BREAK;
         S_BREAK: if (rx_s) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM outputs: busy plus sampling strobes for the datapath
   always_comb begin
      busy      = (state != S_IDLE);
      bit_smp   = (state == S_DATA) && (cnt == FULL_M1);
      stop_good = (state == S_STOP) && (cnt == FULL_M1) && rx_s;
      stop_bad  = (state == S_STOP) && (cnt == FULL_M1) && !rx_s;
   end

   // Bit timing and bit index counters; both restart on every state entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         bit_idx <= '0;
      end else if (state_nx != state) begin
         cnt     <= '0;
         bit_idx <= '0;
      end else if (bit_smp) begin
         cnt     <= '0;
         bit_idx <= bit_idx + BW'(1);
      end else if (state == S_START || state == S_DATA || state == S_STOP) begin
         cnt     <= cnt + CW'(1);
      end
   end

   // LSB-first shift register; a framing error throws the byte away
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         shreg <= '0;
      else if (bit_smp)  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      else if (stop_bad) shreg <= '0;
   end

   // Output register and flags; a set event beats a coincident rd_ack
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out  <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (stop_good && (!rx_valid || rd_ack)) data_out <= shreg;

         if (stop_good)   rx_valid <= 1'b1;
         else if (rd_ack) rx_valid <= 1'b0;

         if (stop_bad)    frame_err <= 1'b1;
         else if (rd_ack) frame_err <= 1'b0;

         if (stop_good && rx_valid && !rd_ack) overrun <= 1'b1;
         else if (rd_ack)                      overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed table of frames plus hand-written corner cases.
module tb_uart_receiver;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       rd_ack = 1'b0;
   logic [7:0] data_out;
   logic       rx_valid, frame_err, overrun, busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       ack;
      logic [7:0] exp_d;
      logic       exp_v;
      logic       exp_fe;
      logic       exp_ov;
   } vec_t;

   vec_t vt[6];

   uart_receiver #(.DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset(reset), .rx(rx), .rd_ack(rd_ack),
      .data_out(data_out), .rx_valid(rx_valid), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] d, input logic v,
                            input logic fe, input logic ov, input logic bz);
      chk({tag, ".data_out"},  {24'h0, data_out}, {24'h0, d});
      chk({tag, ".rx_valid"},  {31'h0, rx_valid}, {31'h0, v});
      chk({tag, ".frame_err"}, {31'h0, frame_err}, {31'h0, fe});
      chk({tag, ".overrun"},   {31'h0, overrun}, {31'h0, ov});
      chk({tag, ".busy"},      {31'h0, busy}, {31'h0, bz});
   endtask

   // Call at a negedge; returns at a negedge with the line idle high
   task automatic send_frame(input logic [7:0] d, input logic stop);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; rx = 1'b1; rd_ack = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic ack_pulse();
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
   endtask

   initial begin
      int n;
      vt[0] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
      vt[1] = '{8'hF0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1};
      vt[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
      vt[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      vt[4] = '{8'h12, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
      vt[5] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      // Good frame 0xA5 with latency measurement
      n = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (!rx_valid && n < 400) begin
               @(posedge clk); #1; n++;
            end
         end
      join
      checks++;
      if (n < 154 || n > 156) begin
         errors++;
         $display("FAIL latency: got %0d cycles expected 155 +/-1", n);
      end
      repeat (4) @(negedge clk);
      check_out("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      ack_pulse();

      // Table of frames
      for (int i = 0; i < 6; i++) begin
         send_frame(vt[i].d, vt[i].stop);
         repeat (4) @(negedge clk);
         check_out($sformatf("vec%0d", i), vt[i].exp_d, vt[i].exp_v,
                   vt[i].exp_fe, vt[i].exp_ov, 1'b0);
         if (vt[i].ack) ack_pulse();
      end

      // Start-bit glitch: short low pulse returns to IDLE untouched
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      chk("glitch.busy_start", {31'h0, busy}, 32'h1);
      repeat (20) @(negedge clk);
      check_out("glitch", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
      ack_pulse();

      // Bad stop bit followed by a held-low line (BREAK)
      do_reset();
      send_frame(8'h3C, 1'b0);
      rx = 1'b0;
      repeat (20) @(negedge clk);
      check_out("break", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      chk("break.exit_busy", {31'h0, busy}, 32'h0);
      send_frame(8'h11, 1'b1);
      repeat (4) @(negedge clk);
      check_out("after_break", 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
      ack_pulse();
      chk("after_break.ack_fe", {31'h0, frame_err}, 32'h0);
      chk("after_break.ack_v",  {31'h0, rx_valid}, 32'h0);

      // Back-to-back frames without rd_ack -> overrun
      do_reset();
      send_frame(8'h55, 1'b1);
      send_frame(8'hAA, 1'b1);
      repeat (4) @(negedge clk);
      check_out("overrun", 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
      ack_pulse();
      check_out("overrun_ack", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);

      // rd_ack exactly in the cycle the second frame completes
      do_reset();
      send_frame(8'h55, 1'b1);
      fork
         send_frame(8'hAA, 1'b1);
         begin
            repeat (154) @(posedge clk);
            @(negedge clk);
            rd_ack = 1'b1;
            @(negedge clk);
            rd_ack = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      check_out("ack_coincident", 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);

      // Reset pulse during data bit 4 of 0xFF
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (11 + 16 * 4 + 6) @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            #1;
            check_out("midreset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            repeat (2) @(negedge clk);
            reset = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      check_out("midreset_after", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h81, 1'b1);
      repeat (4) @(negedge clk);
      check_out("post_reset", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
